// File: rtl/spi_frame_ctrl_if.sv
// rtl/spi_frame_ctrl_if.sv - register-bus bundle between the SPI frame controller and register sources
interface spi_frame_ctrl_if;
  logic [6:0] reg_addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output reg_addr, wr_en, wr_data, rd_req,
    input  rd_data, rd_valid
  );

  modport slave (
    input  reg_addr, wr_en, wr_data, rd_req,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - oversampled SPI mode-0 slave framing a command byte plus data bytes onto the register bus
module spi_frame_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_STATUS  = 8'h00,
  parameter logic [7:0] RD_FILL     = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               mosi,
  input  logic               ce0,
  output logic               miso,
  output logic               busy,
  output logic               frame_err,
  spi_frame_ctrl_if.master   bus
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ce0_sync_q;
  logic                   sclk_prev_q, ce0_prev_q;
  logic                   sclk_s, mosi_s, ce0_s;
  logic                   sclk_rise, sclk_fall, ce0_rise, ce0_fall;

  state_t     state_q;
  logic [7:0] rx_q, tx_q, rx_d, rd_buf_q, wr_data_q, load_d;
  logic [2:0] bitcnt_q;
  logic [6:0] reg_addr_q;
  logic       wr_en_q, rd_req_q, rd_got_q, miso_q, busy_q, frame_err_q, load_ok;

  // ce0 synchronizer resets to deselected so reset release never looks like a frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ce0_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ce0_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ce0_sync_q  <= {ce0_sync_q[SYNC_STAGES-2:0], ce0};
      sclk_prev_q <= sclk_s;
      ce0_prev_q  <= ce0_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ce0_s     = ce0_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ce0_rise  = ce0_s & ~ce0_prev_q;
  assign ce0_fall  = ~ce0_s & ce0_prev_q;

  assign rx_d    = {rx_q[6:0], mosi_s};
  assign load_ok = rd_got_q | bus.rd_valid;
  assign load_d  = bus.rd_valid ? bus.rd_data : (rd_got_q ? rd_buf_q : RD_FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_q        <= '0;
      tx_q        <= '0;
      bitcnt_q    <= '0;
      reg_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_buf_q    <= '0;
      rd_got_q    <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      rd_req_q <= 1'b0;
      if (bus.rd_valid) begin
        rd_buf_q <= bus.rd_data;
        rd_got_q <= 1'b1;
      end
      if (wr_en_q) reg_addr_q <= reg_addr_q + 7'd1;

      // ce0 release outranks any sclk edge detected in the same cycle
      if (ce0_rise) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        miso_q   <= 1'b0;
        tx_q     <= '0;
        bitcnt_q <= '0;
        if (bitcnt_q != 3'd0) frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (ce0_fall) begin
              state_q     <= CMD;
              busy_q      <= 1'b1;
              frame_err_q <= 1'b0;
              bitcnt_q    <= '0;
              tx_q        <= CMD_STATUS;
              miso_q      <= CMD_STATUS[7];
              rd_got_q    <= 1'b0;
            end
          end
          default: begin
            if (sclk_rise) begin
              rx_q     <= rx_d;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                case (state_q)
                  CMD: begin
                    reg_addr_q <= rx_d[6:0];
                    if (rx_d[7]) begin
                      state_q  <= RDATA;
                      rd_req_q <= 1'b1;
                      rd_got_q <= 1'b0;
                    end else begin
                      state_q <= WDATA;
                    end
                  end
                  WDATA: begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= rx_d;
                  end
                  RDATA: begin
                    rd_req_q <= 1'b1;
                    rd_got_q <= 1'b0;
                  end
                  default: ;
                endcase
              end
            end else if (sclk_fall) begin
              // a fall with bitcnt 0 is the 8th fall of the byte just received
              if (state_q == RDATA && bitcnt_q == 3'd0) begin
                tx_q       <= load_d;
                miso_q     <= load_d[7];
                reg_addr_q <= reg_addr_q + 7'd1;
                if (!load_ok) frame_err_q <= 1'b1;
              end else begin
                tx_q   <= {tx_q[6:0], 1'b0};
                miso_q <= tx_q[6];
              end
            end
          end
        endcase
      end
    end
  end

  assign miso         = miso_q & ~ce0;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;
  assign bus.reg_addr = reg_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_req   = rd_req_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb/tb_spi_frame_ctrl.sv - directed self-checking bench for spi_frame_ctrl
module tb_spi_frame_ctrl;
  localparam int HALF = 8;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0, ce0 = 1'b1;
  logic miso, busy, frame_err;
  spi_frame_ctrl_if bus();

  spi_frame_ctrl dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ce0(ce0),
    .miso(miso), .busy(busy), .frame_err(frame_err), .bus(bus)
  );

  int pass_cnt = 0, total_cnt = 0, cyc = 0, last_rise = 0;
  logic [6:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         wr_lat[$];
  logic [6:0] rd_a[$];
  logic [7:0] mem [128];
  logic [7:0] rx [3];
  bit         src_en = 1'b0, pend = 1'b0;
  logic [6:0] pend_a = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_a.push_back(bus.reg_addr);
      wr_d.push_back(bus.wr_data);
      wr_lat.push_back(cyc - last_rise);
    end
    if (bus.rd_req) begin
      rd_a.push_back(bus.reg_addr);
      if (src_en) begin
        pend   = 1'b1;
        pend_a = bus.reg_addr;
      end
    end
  end

  initial begin
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
  end

  always begin
    @(posedge clk);
    #1;
    bus.rd_valid = 1'b0;
    if (pend) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = mem[pend_a];
      pend         = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      rxb[i] = miso;
      sclk = 1'b1;
      last_rise = cyc;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    ce0 = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    ce0 = 1'b1;
    wait_clk(8);
  endtask

  task automatic clear_q();
    wr_a.delete(); wr_d.delete(); wr_lat.delete(); rd_a.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(3);
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (miso !== 1'b0) $display("FAIL rst_miso got %b want 0", miso); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL rst_err got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (bus.reg_addr !== 7'h00) $display("FAIL rst_addr got %h want 00", bus.reg_addr); else pass_cnt++;
    total_cnt++; if (bus.wr_en !== 1'b0 || bus.rd_req !== 1'b0) $display("FAIL rst_strobes got %b%b want 00", bus.wr_en, bus.rd_req); else pass_cnt++;
    total_cnt++; if (bus.wr_data !== 8'h00) $display("FAIL rst_wdata got %h want 00", bus.wr_data); else pass_cnt++;
    rst = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_write();
    clear_q();
    spi_begin();
    total_cnt++; if (busy !== 1'b1) $display("FAIL wr_busy got %b want 1", busy); else pass_cnt++;
    spi_xfer(8'h05, 8, rx[0]);
    spi_xfer(8'hA1, 8, rx[1]);
    spi_xfer(8'hB2, 8, rx[2]);
    spi_end();
    total_cnt++; if (rx[0] !== 8'h00) $display("FAIL wr_status got %h want 00", rx[0]); else pass_cnt++;
    total_cnt++; if (wr_a.size() !== 2) $display("FAIL wr_count got %0d want 2", wr_a.size()); else pass_cnt++;
    if (wr_a.size() == 2) begin
      total_cnt++; if (wr_a[0] !== 7'h05 || wr_d[0] !== 8'hA1) $display("FAIL wr0 got %h/%h want 05/a1", wr_a[0], wr_d[0]); else pass_cnt++;
      total_cnt++; if (wr_a[1] !== 7'h06 || wr_d[1] !== 8'hB2) $display("FAIL wr1 got %h/%h want 06/b2", wr_a[1], wr_d[1]); else pass_cnt++;
      total_cnt++; if (wr_lat[1] !== 3) $display("FAIL wr_latency got %0d want 3", wr_lat[1]); else pass_cnt++;
    end
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL wr_err got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL wr_idle got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_read();
    clear_q();
    src_en = 1'b1;
    mem[3] = 8'h3C; mem[4] = 8'h4D; mem[5] = 8'h5E;
    spi_begin();
    spi_xfer(8'h83, 8, rx[0]);
    spi_xfer(8'h00, 8, rx[1]);
    spi_xfer(8'h00, 8, rx[2]);
    spi_end();
    total_cnt++; if (rx[0] !== 8'h00) $display("FAIL rd_byte0 got %h want 00", rx[0]); else pass_cnt++;
    total_cnt++; if (rx[1] !== 8'h3C) $display("FAIL rd_byte1 got %h want 3c", rx[1]); else pass_cnt++;
    total_cnt++; if (rx[2] !== 8'h4D) $display("FAIL rd_byte2 got %h want 4d", rx[2]); else pass_cnt++;
    total_cnt++; if (rd_a.size() !== 3) $display("FAIL rd_req_count got %0d want 3", rd_a.size()); else pass_cnt++;
    if (rd_a.size() == 3) begin
      total_cnt++; if (rd_a[0] !== 7'h03 || rd_a[1] !== 7'h04 || rd_a[2] !== 7'h05)
        $display("FAIL rd_req_addr got %h,%h,%h want 03,04,05", rd_a[0], rd_a[1], rd_a[2]); else pass_cnt++;
    end
    total_cnt++; if (frame_err !== 1'b0 || wr_a.size() !== 0) $display("FAIL rd_clean got err=%b wr=%0d want 0/0", frame_err, wr_a.size()); else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear_q();
    spi_begin();
    spi_xfer(8'h7F, 8, rx[0]);
    spi_xfer(8'h11, 8, rx[1]);
    spi_xfer(8'h22, 8, rx[2]);
    spi_end();
    total_cnt++; if (wr_a.size() !== 2) $display("FAIL wrap_count got %0d want 2", wr_a.size()); else pass_cnt++;
    if (wr_a.size() == 2) begin
      total_cnt++; if (wr_a[0] !== 7'h7F || wr_d[0] !== 8'h11) $display("FAIL wrap0 got %h/%h want 7f/11", wr_a[0], wr_d[0]); else pass_cnt++;
      total_cnt++; if (wr_a[1] !== 7'h00 || wr_d[1] !== 8'h22) $display("FAIL wrap1 got %h/%h want 00/22", wr_a[1], wr_d[1]); else pass_cnt++;
    end
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL wrap_err got %b want 0", frame_err); else pass_cnt++;
  endtask

  task automatic test_rd_fill();
    clear_q();
    src_en = 1'b0;
    spi_begin();
    spi_xfer(8'h8A, 8, rx[0]);
    spi_xfer(8'h00, 8, rx[1]);
    spi_end();
    total_cnt++; if (rx[1] !== 8'hFF) $display("FAIL fill_byte got %h want ff", rx[1]); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL fill_err got %b want 1", frame_err); else pass_cnt++;
    spi_begin();
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL fill_clear got %b want 0", frame_err); else pass_cnt++;
    spi_end();
    src_en = 1'b1;
  endtask

  task automatic test_abort();
    clear_q();
    spi_begin();
    spi_xfer(8'h10, 8, rx[0]);
    spi_xfer(8'hF0, 4, rx[1]);
    wait_clk(HALF);
    ce0 = 1'b1;
    wait_clk(2);
    total_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_early got %b want 1", busy); else pass_cnt++;
    wait_clk(1);
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL abort_err got %b want 1", frame_err); else pass_cnt++;
    wait_clk(8);
    total_cnt++; if (wr_a.size() !== 0) $display("FAIL abort_wr got %0d want 0", wr_a.size()); else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    clear_q();
    src_en = 1'b1;
    spi_begin();
    spi_xfer(8'h83, 8, rx[0]);
    spi_xfer(8'h00, 4, rx[1]);
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0 || miso !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL rstmid_out got busy=%b miso=%b err=%b want 000", busy, miso, frame_err); else pass_cnt++;
    total_cnt++; if (bus.reg_addr !== 7'h00 || bus.rd_req !== 1'b0 || bus.wr_en !== 1'b0)
      $display("FAIL rstmid_bus got addr=%h rd=%b wr=%b want 00/0/0", bus.reg_addr, bus.rd_req, bus.wr_en); else pass_cnt++;
    ce0 = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(8);
    clear_q();
    spi_begin();
    spi_xfer(8'h22, 8, rx[0]);
    spi_xfer(8'h5A, 8, rx[1]);
    spi_end();
    total_cnt++; if (wr_a.size() !== 1) $display("FAIL rstmid_count got %0d want 1", wr_a.size()); else pass_cnt++;
    if (wr_a.size() == 1) begin
      total_cnt++; if (wr_a[0] !== 7'h22 || wr_d[0] !== 8'h5A) $display("FAIL rstmid_wr got %h/%h want 22/5a", wr_a[0], wr_d[0]); else pass_cnt++;
    end
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL rstmid_err got %b want 0", frame_err); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_rd_fill();
    test_abort();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
